// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with a 16x oversampling tick and 2-flop rx synchronizer.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx_oversampled #(
  parameter logic [31:0] baudrate  = 32'd9600,
  parameter logic [31:0] frequency = 32'd100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);

  localparam logic [31:0] DIV = frequency / (baudrate * 32'd16);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic [3:0]    r_s;
  logic [2:0]    r_n;
  logic [7:0]    r_shift;
  logic          r_ok;
  logic          r_bad;
  logic          r_perr;

  state_t        w_state_nxt;
  logic [3:0]    w_s_nxt;
  logic [2:0]    w_n_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_ok_nxt;
  logic          w_bad_nxt;
  logic          w_perr_nxt;
  logic          w_tick;
  logic          w_rx_s;

`ifdef UART_RX_PARITY_EN
  logic          r_par;
  logic          w_par_nxt;
`endif

  assign w_rx_s = r_sync2;
  assign w_tick = (r_cnt == CNT_MAX);
  assign busy   = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_shift_nxt = r_shift;
    w_ok_nxt    = 1'b0;
    w_bad_nxt   = 1'b0;
    w_perr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            w_s_nxt     = 4'd0;
            w_state_nxt = S_START;
          end
        end
        S_START: begin
          // Mid start bit: a high line here was only a glitch
          if (r_s == 4'd7) begin
            if (!w_rx_s) begin
              w_s_nxt     = 4'd0;
              w_n_nxt     = 3'd0;
              w_state_nxt = S_DATA;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
        S_DATA: begin
          if (r_s == 4'd15) begin
            w_shift_nxt = {w_rx_s, r_shift[7:1]};
            w_s_nxt     = 4'd0;
            if (r_n == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end else begin
              w_n_nxt = r_n + 3'd1;
            end
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_s == 4'd15) begin
            w_par_nxt   = w_rx_s;
            w_s_nxt     = 4'd0;
            w_state_nxt = S_STOP;
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
`endif
        S_STOP: begin
          if (r_s == 4'd15) begin
            w_ok_nxt    = w_rx_s;
            w_bad_nxt   = !w_rx_s;
`ifdef UART_RX_PARITY_EN
            w_perr_nxt  = ^{r_shift, r_par};
`endif
            w_state_nxt = S_IDLE;
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_s     <= 4'd0;
      r_n     <= 3'd0;
      r_shift <= 8'd0;
      r_ok    <= 1'b0;
      r_bad   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_shift <= w_shift_nxt;
      r_ok    <= w_ok_nxt;
      r_bad   <= w_bad_nxt;
      r_perr  <= w_perr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) r_par <= 1'b0;
    else       r_par <= w_par_nxt;
  end
`endif

  // Outcome pulses land one edge after the deciding tick
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out      <= 8'd0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid    <= r_ok;
      framing_error <= r_bad;
      if (r_ok) data_out <= r_shift;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) parity_error <= 1'b0;
    else       parity_error <= r_perr;
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Randomized frame-level bench for uart_rx_oversampled.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx_oversampled;

  localparam int CPB = 160;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic       f;
    logic       p;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  int         n_checks = 0;
  int         n_err = 0;
  ev_t        obs[$];
  logic [7:0] last_good = 8'd0;

  uart_rx_oversampled #(
    .baudrate (32'd10000),
    .frequency(32'd1600000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .parity_error (parity_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ev_t e;
    if (!reset && (data_valid || framing_error || parity_error)) begin
      e = '{v: data_valid, f: framing_error, p: parity_error, d: data_out};
      obs.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] d,
                          input logic stop, input logic par);
    ev_t e;
    ev_t g;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (i == 2) check({tag, "_busy_mid"}, busy, 1);
    end
    if (PAR_EN) send_bit(par);
    send_bit(stop);
    rx = 1'b1;
    e.v = stop;
    e.f = !stop;
    e.p = PAR_EN && ((^d) ^ par);
    e.d = stop ? d : last_good;
    if (stop) last_good = d;
    check({tag, "_nev"}, obs.size(), 1);
    if (obs.size() > 0) begin
      g = obs.pop_front();
      check({tag, "_valid"}, g.v, e.v);
      check({tag, "_ferr"}, g.f, e.f);
      check({tag, "_perr"}, g.p, e.p);
      check({tag, "_data"}, g.d, e.d);
    end
    obs.delete();
    if (stop) check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       st;
    repeat (3) @(negedge clk);
    check("rst_data", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_ferr", framing_error, 0);
    check("rst_perr", parity_error, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (200) @(negedge clk);

    do_frame("a5", 8'hA5, 1'b1, ^8'hA5);
    repeat (200) @(negedge clk);

    do_frame("b2b0", 8'h00, 1'b1, 1'b0);
    do_frame("b2b1", 8'hFF, 1'b1, 1'b0);
    repeat (200) @(negedge clk);

    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_busy", busy, 0);
    repeat (200) @(negedge clk);
    check("glitch_nev", obs.size(), 0);
    obs.delete();

    do_frame("g11", 8'h11, 1'b1, ^8'h11);
    do_frame("fe3c", 8'h3C, 1'b0, ^8'h3C);
    repeat (200) @(negedge clk);

    d = 8'h96;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_data", data_out, 0);
    check("mrst_valid", data_valid, 0);
    check("mrst_ferr", framing_error, 0);
    check("mrst_busy", busy, 0);
    rx = 1'b1;
    last_good = 8'd0;
    repeat (2 * CPB) @(negedge clk);
    check("mrst_nev", obs.size(), 0);
    obs.delete();
    do_frame("post5a", 8'h5A, 1'b1, ^8'h5A);
    repeat (200) @(negedge clk);

    if (PAR_EN) begin
      do_frame("par07bad", 8'h07, 1'b1, 1'b0);
      repeat (200) @(negedge clk);
      do_frame("par07ok", 8'h07, 1'b1, 1'b1);
      repeat (200) @(negedge clk);
    end

    for (int k = 0; k < 20; k++) begin
      d = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      do_frame($sformatf("rnd%0d", k), d, st, 1'($urandom));
      if (st) repeat ($urandom_range(0, 100)) @(negedge clk);
      else repeat (CPB + $urandom_range(0, 100)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
